axi4_lite_reg_slave: RTL and testbench



---
 rtl/axi4_lite_pkg.sv | 19 +
 rtl/axi4_lite_reg_array.sv | 48 ++++
 rtl/axi4_lite_reg_slave.sv | 195 +++++++++++++++++++
 tb/tb_axi4_lite_reg_slave.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared response codes and channel FSM state encodings for the AXI4-Lite register slave.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/axi4_lite_reg_array.sv
// Register storage with a strobe-merged write port and one combinational read port.
// Index 0 is a read-only ID; writes land one cycle after i_we, reads are same-cycle.
module axi4_lite_reg_array
    import axi4_lite_pkg::*;
#(
    parameter int          data_width = 32,
    parameter int          strb_width = data_width / 8,
    parameter int          num_regs   = 16,
    parameter logic [31:0] id_value   = 32'h53494D42,
    parameter int          idx_w      = $clog2(num_regs)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [idx_w-1:0]      i_widx,
    input  logic [data_width-1:0] i_wdata,
    input  logic [strb_width-1:0] i_wstrb,
    input  logic [idx_w-1:0]      i_ridx,
    output logic [data_width-1:0] o_rdata
);

    localparam logic [data_width-1:0] ID_EXT = data_width'(id_value);

    logic [data_width-1:0] r_regs [num_regs];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < num_regs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_widx != '0)) begin
            for (int b = 0; b < strb_width; b++) begin
                if (i_wstrb[b]) begin
                    r_regs[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Slot 0 is never written, so the ID is substituted on the read side.
    always_comb begin
        o_rdata = r_regs[i_ridx];
        if (i_ridx == '0) begin
            o_rdata = ID_EXT;
        end
    end

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register slave: one outstanding write and one outstanding read on independent channels.
// Response appears the cycle after the completing handshake and holds until BREADY/RREADY.
module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int          data_width = 32,
    parameter int          addr_width = 32,
    parameter int          strb_width = data_width / 8,
    parameter int          num_regs   = 16,
    parameter logic [31:0] id_value   = 32'h53494D42
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [addr_width-1:0] AWADDR,
    input  logic [2:0]            AWPROT,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic [data_width-1:0] WDATA,
    input  logic [strb_width-1:0] WSTRB,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [1:0]            BRESP,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [addr_width-1:0] ARADDR,
    input  logic [2:0]            ARPROT,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [data_width-1:0] RDATA,
    output logic [1:0]            RRESP
);

    localparam int OFFS_W = $clog2(strb_width);
    localparam int IDX_W  = $clog2(num_regs);
    localparam logic [addr_width-1:0] ADDR_LIMIT = addr_width'(num_regs * strb_width);

    wr_state_t r_wstate, w_wstate_nxt;
    rd_state_t r_rstate, w_rstate_nxt;

    logic [IDX_W-1:0]      r_aw_idx;
    logic                  r_aw_oor;
    logic [data_width-1:0] r_wdata;
    logic [strb_width-1:0] r_wstrb;
    logic [1:0]            r_bresp;
    logic [data_width-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_aw_hs, w_w_hs, w_ar_hs;
    logic [IDX_W-1:0]      w_aw_idx, w_ar_idx, w_c_idx;
    logic                  w_aw_oor, w_ar_oor, w_c_oor;
    logic [data_width-1:0] w_c_data, w_arr_rdata;
    logic [strb_width-1:0] w_c_strb;
    logic                  w_commit;
    logic                  w_unused_ok;

    assign w_unused_ok = ^{AWPROT, ARPROT, AWADDR, ARADDR};

    assign w_aw_idx = AWADDR[OFFS_W +: IDX_W];
    assign w_ar_idx = ARADDR[OFFS_W +: IDX_W];
    assign w_aw_oor = (AWADDR >= ADDR_LIMIT);
    assign w_ar_oor = (ARADDR >= ADDR_LIMIT);

    assign AWREADY = !ARESET && ((r_wstate == W_IDLE) || (r_wstate == W_DATA));
    assign WREADY  = !ARESET && ((r_wstate == W_IDLE) || (r_wstate == W_ADDR));
    assign ARREADY = !ARESET && (r_rstate == R_IDLE);

    assign w_aw_hs = AWVALID && AWREADY;
    assign w_w_hs  = WVALID && WREADY;
    assign w_ar_hs = ARVALID && ARREADY;

    assign BVALID = (r_wstate == W_RESP);
    assign BRESP  = r_bresp;
    assign RVALID = (r_rstate == R_RESP);
    assign RDATA  = r_rdata;
    assign RRESP  = r_rresp;

    // Whichever half arrived first comes from the holding registers, the other from the bus.
    assign w_c_idx  = (r_wstate == W_ADDR) ? r_aw_idx : w_aw_idx;
    assign w_c_oor  = (r_wstate == W_ADDR) ? r_aw_oor : w_aw_oor;
    assign w_c_data = (r_wstate == W_DATA) ? r_wdata  : WDATA;
    assign w_c_strb = (r_wstate == W_DATA) ? r_wstrb  : WSTRB;

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_commit     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end else if (w_aw_hs) begin
                    w_wstate_nxt = W_ADDR;
                end else if (w_w_hs) begin
                    w_wstate_nxt = W_DATA;
                end
            end
            W_ADDR: begin
                if (w_w_hs) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_DATA: begin
                if (w_aw_hs) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_aw_idx <= '0;
            r_aw_oor <= 1'b0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_idx <= w_aw_idx;
                r_aw_oor <= w_aw_oor;
            end
            if (w_w_hs) begin
                r_wdata <= WDATA;
                r_wstrb <= WSTRB;
            end
            if (w_commit) begin
                r_bresp <= w_c_oor ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_RESP;
            R_RESP:  if (RREADY)  w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    // The array read port sees pre-edge contents, so a colliding write is not visible yet.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_ar_oor ? '0 : w_arr_rdata;
            r_rresp <= w_ar_oor ? RESP_SLVERR : RESP_OKAY;
        end
    end

    axi4_lite_reg_array #(
        .data_width (data_width),
        .strb_width (strb_width),
        .num_regs   (num_regs),
        .id_value   (id_value),
        .idx_w      (IDX_W)
    ) u_reg_array (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_we    (w_commit && !w_c_oor),
        .i_widx  (w_c_idx),
        .i_wdata (w_c_data),
        .i_wstrb (w_c_strb),
        .i_ridx  (w_ar_idx),
        .o_rdata (w_arr_rdata)
    );

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave: hand-computed expectations checked with immediate assertions.
module tb_axi4_lite_reg_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        AWVALID, AWREADY;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        WVALID, WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID, BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID, ARREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        RVALID, RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    int n_cmp  = 0;
    int n_fail = 0;

    axi4_lite_reg_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
        logic awh, wh;
        AWADDR = a; AWVALID = 1'b1;
        WDATA  = d; WSTRB   = s; WVALID = 1'b1;
        for (int i = 0; i < 20 && (AWVALID || WVALID); i++) begin
            awh = AWVALID && AWREADY;
            wh  = WVALID && WREADY;
            tick();
            if (awh) AWVALID = 1'b0;
            if (wh)  WVALID  = 1'b0;
        end
        chk({tag, "_accepted"}, {AWVALID, WVALID}, 2'b00);
        AWVALID = 1'b0; WVALID = 1'b0;
        chk({tag, "_bvalid"}, BVALID, 1'b1);
        resp = BRESP;
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] a,
                           output logic [31:0] d, output logic [1:0] resp);
        logic arh;
        ARADDR = a; ARVALID = 1'b1;
        for (int i = 0; i < 20 && ARVALID; i++) begin
            arh = ARREADY;
            tick();
            if (arh) ARVALID = 1'b0;
        end
        chk({tag, "_ar_accepted"}, ARVALID, 1'b0);
        ARVALID = 1'b0;
        chk({tag, "_rvalid"}, RVALID, 1'b1);
        d = RDATA;
        resp = RRESP;
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs, bs;
        int          cnt;

        ARESET = 1'b1;
        AWVALID = 1'b0; AWADDR = '0; AWPROT = 3'b000;
        WVALID = 1'b0;  WDATA = '0;  WSTRB = '0;
        BREADY = 1'b0;
        ARVALID = 1'b0; ARADDR = '0; ARPROT = 3'b000;
        RREADY = 1'b0;

        // Reset held three cycles
        tick(); tick(); tick();
        chk("rst_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
        chk("rst_valids", {BVALID, RVALID}, 2'b00);
        chk("rst_bresp", BRESP, 2'b00);
        chk("rst_rdata", RDATA, 32'h0);
        chk("rst_rresp", RRESP, 2'b00);
        ARESET = 1'b0;
        #1;
        chk("post_rst_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
        tick();

        do_read("id", 32'h0, rd, rs);
        chk("id_rdata", rd, 32'h53494D42);
        chk("id_rresp", rs, 2'b00);

        // Address and data in the same cycle
        do_write("w4", 32'h4, 32'hDEADBEEF, 4'hF, bs);
        chk("w4_bresp", bs, 2'b00);
        do_read("r4", 32'h4, rd, rs);
        chk("r4_rdata", rd, 32'hDEADBEEF);
        chk("r4_rresp", rs, 2'b00);

        // Data two cycles ahead of address, partial strobe
        do_write("w8a", 32'h8, 32'hAABBCCDD, 4'hF, bs);
        WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("wfirst_ready", {AWREADY, WREADY, BVALID}, 3'b100);
        tick();
        AWADDR = 32'h8; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("wfirst_bvalid", BVALID, 1'b1);
        chk("wfirst_bresp", BRESP, 2'b00);
        BREADY = 1'b1; tick(); BREADY = 1'b0;
        do_read("r8", 32'h8, rd, rs);
        chk("r8_rdata", rd, 32'hAA22CC44);

        // Out of range and read-only ID
        do_write("w40", 32'h40, 32'hFFFFFFFF, 4'hF, bs);
        chk("w40_bresp", bs, 2'b10);
        do_write("w44", 32'h44, 32'h01010101, 4'hF, bs);
        chk("w44_bresp", bs, 2'b10);
        do_read("r40", 32'h40, rd, rs);
        chk("r40_rdata", rd, 32'h0);
        chk("r40_rresp", rs, 2'b10);
        do_read("r4_after_oor", 32'h4, rd, rs);
        chk("r4_after_oor_rdata", rd, 32'hDEADBEEF);
        do_write("w0", 32'h0, 32'h12345678, 4'hF, bs);
        chk("w0_bresp", bs, 2'b00);
        do_read("id2", 32'h0, rd, rs);
        chk("id2_rdata", rd, 32'h53494D42);

        // Write response held off for five cycles
        AWADDR = 32'hC; WDATA = 32'h0000CAFE; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bstall_valid", BVALID, 1'b1);
            chk("bstall_resp", BRESP, 2'b00);
            chk("bstall_ready", {AWREADY, WREADY}, 2'b00);
            tick();
        end
        BREADY = 1'b1; tick(); BREADY = 1'b0;
        chk("bstall_done", {BVALID, AWREADY, WREADY}, 3'b011);

        // Read response held off for five cycles
        ARADDR = 32'h4; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("rstall_valid", RVALID, 1'b1);
            chk("rstall_data", RDATA, 32'hDEADBEEF);
            chk("rstall_arready", ARREADY, 1'b0);
            tick();
        end
        RREADY = 1'b1; tick(); RREADY = 1'b0;
        chk("rstall_done", {RVALID, ARREADY}, 2'b01);

        // Read and write to 0xC on the same edge
        AWADDR = 32'hC; WDATA = 32'h0BADF00D; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 32'hC; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        chk("coll_valids", {BVALID, RVALID}, 2'b11);
        chk("coll_rdata", RDATA, 32'h0000CAFE);
        BREADY = 1'b1; RREADY = 1'b1; tick(); BREADY = 1'b0; RREADY = 1'b0;
        do_read("rc", 32'hC, rd, rs);
        chk("rc_rdata", rd, 32'h0BADF00D);

        // RREADY tied high: one read every two cycles
        RREADY = 1'b1; ARADDR = 32'h0; ARVALID = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (RVALID) cnt++;
        end
        ARVALID = 1'b0;
        tick();
        RREADY = 1'b0;
        chk("b2b_reads", cnt, 3);

        // Reset with only the address half captured
        AWADDR = 32'hC; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("half_state", {AWREADY, WREADY, BVALID}, 3'b010);
        ARESET = 1'b1; WDATA = 32'hFFFFFFFF; WVALID = 1'b1;
        #1;
        chk("half_rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
        tick();
        chk("half_rst_bvalid", BVALID, 1'b0);
        tick();
        ARESET = 1'b0; WVALID = 1'b0;
        tick();
        chk("half_post_bvalid", BVALID, 1'b0);
        chk("half_post_ready", {AWREADY, WREADY}, 2'b11);
        tick();
        chk("half_post_bvalid2", BVALID, 1'b0);
        do_read("rc_rst", 32'hC, rd, rs);
        chk("rc_rst_rdata", rd, 32'h0);
        do_read("r4_rst", 32'h4, rd, rs);
        chk("r4_rst_rdata", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
